// File: rtl/axis_uart_tx_fifo.sv
// axis_uart_tx_fifo: AXI-Stream fed UART transmitter with a word FIFO.
//   Ports: aclk (clock), areset (async active-high reset), tdata/tvalid/tready
//   (AXI-Stream sink), TX (registered UART line, idle high), busy (frame on line
//   or FIFO non-empty), fifo_level (words stored).
//   Optional macro AXIS_UART_TX_CTS_EN adds cts_n (active-low clear-to-send).
module axis_uart_tx_fifo #(
    parameter int CLK_FREQ   = 100,
    parameter int BIT_RATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    localparam int TW = (DATA_BITS <= 8) ? 8 : 16,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [TW-1:0] tdata,
    input  logic          tvalid,
    output logic          tready,
    output logic          TX,
    output logic          busy,
`ifdef AXIS_UART_TX_CTS_EN
    input  logic          cts_n,
`endif
    output logic [LW-1:0] fifo_level
);
    localparam int DIVISOR = CLK_FREQ * 1000000 / BIT_RATE;
    localparam int AW = LW - 1;
    localparam int CW = $clog2(STOP_BITS * DIVISOR + 2);
    localparam logic [CW-1:0] BIT_LD = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] STOP_LD = CW'(STOP_BITS * DIVISOR - 1);
    localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    if (DIVISOR < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("axis_uart_tx_fifo: illegal parameter set");
    end

    if (TW > DATA_BITS) begin : g_unused
        logic unused_bits;
        assign unused_bits = ^tdata[TW-1:DATA_BITS];
    end

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic                 ready_en;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx_r;
    logic                 gate, empty, push, pop, bit_end;
    logic [DATA_BITS-1:0] head;

`ifdef AXIS_UART_TX_CTS_EN
    logic [1:0] cts_s;
    always_ff @(posedge aclk or posedge areset)
        if (areset) cts_s <= 2'b11;
        else        cts_s <= {cts_s[0], cts_n};
    assign gate = !cts_s[1];
`else
    assign gate = 1'b1;
`endif

    assign empty      = level == '0;
    // ready_en keeps tready low through reset and raises it on the first edge after release
    assign tready     = ready_en && level != FULL;
    assign push       = tvalid && tready;
    assign bit_end    = cnt == '0;
    // a new frame may begin from idle or straight out of the last stop-bit cycle
    assign pop        = (state == ST_IDLE || (state == ST_STOP && bit_end)) && !empty && gate;
    assign head       = mem[rd_ptr];
    assign busy       = state != ST_IDLE || !empty;
    assign fifo_level = level;
    assign TX         = tx_r;

    always_ff @(posedge aclk)
        if (push) mem[wr_ptr] <= tdata[DATA_BITS-1:0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx_r    <= 1'b1;
        end else if (pop) begin
            state   <= ST_START;
            cnt     <= BIT_LD;
            bit_idx <= '0;
            shreg   <= head;
            par_bit <= (^head) ^ (PARITY == 1);
            tx_r    <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (!bit_end) cnt <= cnt - 1'b1;
            else begin
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        cnt   <= BIT_LD;
                        tx_r  <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                    ST_DATA: begin
                        if (bit_idx == LAST) begin
                            state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            cnt   <= (PARITY != 0) ? BIT_LD : STOP_LD;
                            tx_r  <= (PARITY != 0) ? par_bit : 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            cnt     <= BIT_LD;
                            tx_r    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        cnt   <= STOP_LD;
                        tx_r  <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
// tb_axis_uart_tx_fifo: directed bench for axis_uart_tx_fifo at DIVISOR=10.
//   Instances: 0=8N1, 1=8E2, 2=8O1, 3=9N1, 4=5N1, all FIFO_DEPTH=16.
module tb_axis_uart_tx_fifo;
    logic        aclk, areset, cts_n;
    logic [15:0] tdata;
    logic [4:0]  tv, tr, tx, bz;
    logic [4:0]  lvl [5];
    int          errors = 0, checks = 0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int DB = (g == 3) ? 9 : (g == 4) ? 5 : 8;
        localparam int TW = (DB > 8) ? 16 : 8;
        axis_uart_tx_fifo #(
            .CLK_FREQ(100), .BIT_RATE(10_000_000), .DATA_BITS(DB),
            .PARITY((g == 1) ? 2 : (g == 2) ? 1 : 0), .STOP_BITS((g == 1) ? 2 : 1),
            .FIFO_DEPTH(16)
        ) u_dut (
            .aclk(aclk), .areset(areset), .tdata(tdata[TW-1:0]), .tvalid(tv[g]),
            .tready(tr[g]), .TX(tx[g]), .busy(bz[g]),
`ifdef AXIS_UART_TX_CTS_EN
            .cts_n(cts_n),
`endif
            .fifo_level(lvl[g])
        );
    end

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] d);
        tdata = d;
        tv[k] = 1'b1;
        @(negedge aclk);
        tv[k] = 1'b0;
    endtask

    task automatic wait_start(input int k, input int max, input int exp, input string tag);
        int c = 0;
        while (tx[k] && c < max) begin
            @(negedge aclk);
            c++;
        end
        chk(tag, 32'(c), 32'(exp));
    endtask

    // Entered at the falling clock edge just after TX went low; samples mid-bit.
    task automatic frame(input int k, input logic [15:0] seq, input int n, input int len,
                         input bit nxt, input string tag);
        logic [15:0] got;
        got = '0;
        repeat (5) @(negedge aclk);
        got[0] = tx[k];
        for (int i = 1; i < n; i++) begin
            repeat (10) @(negedge aclk);
            got[i] = tx[k];
        end
        repeat (len - 10 * n + 4) @(negedge aclk);
        chk({tag, "_bits"}, 32'(got), 32'(seq));
        chk({tag, "_tail"}, 32'({tx[k], bz[k]}), 32'b11);
        @(negedge aclk);
        chk({tag, "_next"}, 32'(tx[k]), 32'(!nxt));
    endtask

    logic [7:0] w [17];

    initial begin
        areset = 1'b1;
        cts_n  = 1'b0;
        tv     = '0;
        tdata  = '0;
        for (int i = 0; i < 17; i++) w[i] = 8'(i * 29 + 3);
        repeat (3) @(negedge aclk);
        chk("rst_tx", 32'(tx), 32'h1F);
        chk("rst_tready", 32'(tr), 32'h0);
        chk("rst_busy", 32'(bz), 32'h0);
        chk("rst_level", 32'(lvl[0]), 32'h0);
        areset = 1'b0;
        chk("rel_tready_hold", 32'(tr), 32'h0);
        @(negedge aclk);
        chk("rel_tready_up", 32'(tr), 32'h1F);

        push(0, 16'hA5);
        chk("a5_level", 32'(lvl[0]), 32'd1);
        wait_start(0, 5, 1, "a5_start");
        frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 100, 1'b0, "a5");
        chk("a5_idle", 32'(bz[0]), 32'd0);

        push(1, 16'h07);
        wait_start(1, 5, 1, "e2_start");
        frame(1, 16'({2'b11, 1'b1, 8'h07, 1'b0}), 12, 120, 1'b0, "e2");
        chk("e2_idle", 32'(bz[1]), 32'd0);

        push(2, 16'h07);
        wait_start(2, 5, 1, "o1_start");
        frame(2, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 110, 1'b0, "o1");
        chk("o1_idle", 32'(bz[2]), 32'd0);

        push(3, 16'h01FF);
        wait_start(3, 5, 1, "d9_start");
        frame(3, 16'({1'b1, 9'h1FF, 1'b0}), 11, 110, 1'b0, "d9");
        chk("d9_idle", 32'(bz[3]), 32'd0);

        push(4, 16'h00FF);
        wait_start(4, 5, 1, "d5_start");
        frame(4, 16'({1'b1, 5'h1F, 1'b0}), 7, 70, 1'b0, "d5");
        chk("d5_idle", 32'(bz[4]), 32'd0);

        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    tdata = 16'(w[i]);
                    tv[0] = 1'b1;
                    @(negedge aclk);
                end
                tv[0] = 1'b0;
                chk("burst_level", 32'(lvl[0]), 32'd16);
                chk("burst_tready", 32'(tr[0]), 32'd0);
            end
            begin
                wait_start(0, 5, 2, "burst_start");
                for (int i = 0; i < 17; i++)
                    frame(0, 16'({1'b1, w[i], 1'b0}), 10, 100, i < 16, $sformatf("burst%0d", i));
                chk("burst_idle", 32'(bz[0]), 32'd0);
            end
        join

        push(0, 16'h52);
        push(0, 16'h11);
        wait_start(0, 5, 0, "ar_start");
        repeat (44) @(negedge aclk);
        chk("ar_pre_tx", 32'(tx[0]), 32'd0);
        chk("ar_pre_level", 32'(lvl[0]), 32'd1);
        areset = 1'b1;
        #1;
        chk("ar_tx", 32'(tx[0]), 32'd1);
        chk("ar_level", 32'(lvl[0]), 32'd0);
        chk("ar_tready", 32'(tr[0]), 32'd0);
        chk("ar_busy", 32'(bz[0]), 32'd0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        chk("ar_tready_up", 32'(tr[0]), 32'd1);
        chk("ar_tx_idle", 32'(tx[0]), 32'd1);
        push(0, 16'h3C);
        wait_start(0, 5, 1, "x3c_start");
        frame(0, 16'({1'b1, 8'h3C, 1'b0}), 10, 100, 1'b0, "x3c");
        chk("x3c_idle", 32'(bz[0]), 32'd0);

`ifdef AXIS_UART_TX_CTS_EN
        cts_n = 1'b1;
        repeat (3) @(negedge aclk);
        push(0, 16'h96);
        push(0, 16'h4B);
        repeat (20) @(negedge aclk);
        chk("cts_hold_tx", 32'(tx[0]), 32'd1);
        chk("cts_hold_level", 32'(lvl[0]), 32'd2);
        cts_n = 1'b0;
        wait_start(0, 10, 3, "cts_start");
        fork
            frame(0, 16'({1'b1, 8'h96, 1'b0}), 10, 100, 1'b0, "cts_f1");
            begin
                repeat (30) @(negedge aclk);
                cts_n = 1'b1;
            end
        join
        repeat (20) @(negedge aclk);
        chk("cts_held_tx", 32'(tx[0]), 32'd1);
        chk("cts_held_level", 32'(lvl[0]), 32'd1);
        cts_n = 1'b0;
        wait_start(0, 10, 3, "cts_start2");
        frame(0, 16'({1'b1, 8'h4B, 1'b0}), 10, 100, 1'b0, "cts_f2");
        chk("cts_idle", 32'(bz[0]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
